// File: rtl/ram_reader_pkg.sv
// rtl/ram_reader_pkg.sv - shared state type, FIFO depth and address-width helper for ram_stream_reader
package ram_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_FIN
    } reader_state_e;

    localparam int READ_FIFO_DEPTH = 2;

    function automatic int addr_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

endpackage

// File: rtl/ram_reader_skid_fifo.sv
// rtl/ram_reader_skid_fifo.sv - 2-entry synchronous FIFO absorbing RAM read latency against stream backpressure
module ram_reader_skid_fifo
    import ram_reader_pkg::*;
#(
    parameter int  WIDTH = 8,
    localparam int CW    = $clog2(READ_FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [READ_FIFO_DEPTH];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(READ_FIFO_DEPTH));
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign pop_ok  = pop & ~empty;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - drains words 0..length-1 of RAM port B into a valid/ready stream
// Optional RAM_READER_WIPE_EN: every read also zeroes the location it reads (read-first port).
module ram_stream_reader
    import ram_reader_pkg::*;
#(
    parameter int  MEM_WIDTH = 8,
    parameter int  MEM_SIZE  = 896,
    localparam int AW        = addr_width(MEM_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [AW:0]          length,
    output logic                 busy,
    output logic                 done,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [AW-1:0]        ram_addr,
    output logic [MEM_WIDTH-1:0] ram_din,
    input  logic [MEM_WIDTH-1:0] ram_dout,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [MEM_WIDTH-1:0] m_data,
    output logic                 m_last
);

    localparam int CW = $clog2(READ_FIFO_DEPTH + 1);

    reader_state_e state_q, state_d;
    logic [AW:0]   len_q;
    logic [AW:0]   issue_cnt_q;
    logic [AW:0]   deliv_cnt_q;
    logic [AW-1:0] addr_q;
    logic          inflight_q;
    logic          issue;
    logic          pop;
    logic          credit_ok;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   slots_used;

    ram_reader_skid_fifo #(
        .WIDTH (MEM_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (ram_dout),
        .pop       (pop),
        .head      (m_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign m_valid    = ~fifo_empty;
    assign pop        = m_valid & m_ready;
    // the slot freed by this cycle's handshake counts as credit, giving 1 word/cycle
    assign slots_used = {1'b0, fifo_count} + (CW+1)'(inflight_q);
    assign credit_ok  = (~fifo_full | pop)
                      & (slots_used < ((CW+1)'(READ_FIFO_DEPTH) + (CW+1)'(pop)));
    assign issue      = (state_q == ST_RUN) && (issue_cnt_q < len_q) && credit_ok;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = (length == '0) ? ST_FIN : ST_RUN;
            ST_RUN:   if (issue_cnt_q == len_q) state_d = ST_FLUSH;
            ST_FLUSH: if ((deliv_cnt_q + (AW+1)'(pop)) == len_q) state_d = ST_FIN;
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            issue_cnt_q <= '0;
            deliv_cnt_q <= '0;
            addr_q      <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            if (state_q == ST_IDLE && start) begin
                len_q       <= length;
                issue_cnt_q <= '0;
                deliv_cnt_q <= '0;
            end
            if (issue) begin
                issue_cnt_q <= issue_cnt_q + (AW+1)'(1);
                addr_q      <= issue_cnt_q[AW-1:0];
            end
            if (pop) begin
                deliv_cnt_q <= deliv_cnt_q + (AW+1)'(1);
            end
        end
    end

    assign busy     = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign done     = (state_q == ST_FIN);
    assign ram_en   = issue;
    assign ram_addr = issue ? issue_cnt_q[AW-1:0] : addr_q;
    assign m_last   = m_valid & (deliv_cnt_q == (len_q - (AW+1)'(1)));

`ifdef RAM_READER_WIPE_EN
    assign ram_we   = issue;
    assign ram_din  = '0;
`else
    assign ram_we   = 1'b0;
    assign ram_din  = '0;
`endif

endmodule
